// File: rtl/tx_pkg.sv
// Shared transmit-path definitions.
// Capture FSM encodings and the FIR output word width.
package tx_pkg;

  localparam int NB_DATA_DEF = 13;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    FULL = 2'b10,
    READ = 2'b11
  } cap_state_e;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM.
// One write port, one read port, registered read output.
module capture_ram
  import tx_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_ADDR = 4
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_we,
  input  logic [NB_ADDR-1:0] i_waddr,
  input  logic [NB_DATA-1:0] i_wdata,
  input  logic               i_re,
  input  logic [NB_ADDR-1:0] i_raddr,
  output logic [NB_DATA-1:0] o_rdata
);

  logic [NB_DATA-1:0] mem [2**NB_ADDR];
  logic [NB_DATA-1:0] rdata_d;
  logic [NB_DATA-1:0] rdata_q;

  // Write port; contents survive reset.
  always_ff @(posedge clock) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  // Read data holds unless a read is issued.
  always_comb begin
    rdata_d = rdata_q;
    if (i_re) begin
      rdata_d = mem[i_raddr];
    end
  end

  // Read output register.
  always_ff @(posedge clock) begin
    if (!i_reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/fir_capture_ram.sv
// FIR output capture buffer.
// Arm, fill to depth, then sequential readout.
module fir_capture_ram
  import tx_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_ADDR = 4
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_start,
  input  logic               i_rd_req,
  output logic [NB_DATA-1:0] o_rd_data,
  output logic               o_rd_valid,
  output logic               o_full,
  output logic [1:0]         o_state,
  output logic [NB_ADDR:0]   o_count
);

  localparam logic [NB_ADDR-1:0] LAST = '1;

  cap_state_e         state_d, state_q;
  logic [NB_ADDR-1:0] wr_ptr_d, wr_ptr_q;
  logic [NB_ADDR-1:0] rd_ptr_d, rd_ptr_q;
  logic [NB_ADDR:0]   count_d, count_q;
  logic               full_d, full_q;
  logic               rd_valid_d, rd_valid_q;
  logic               we;
  logic               re;

  // Next state, pointers and RAM strobes.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    full_d     = full_q;
    rd_valid_d = 1'b0;
    we         = 1'b0;
    re         = 1'b0;
    if (i_start && state_q != FILL) begin
      state_d  = FILL;
      wr_ptr_d = '0;
      count_d  = '0;
      full_d   = 1'b0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (i_valid) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + NB_ADDR'(1);
            count_d  = count_q + (NB_ADDR+1)'(1);
            if (wr_ptr_q == LAST) begin
              state_d  = FULL;
              rd_ptr_d = '0;
              full_d   = 1'b1;
            end
          end
        end
        FULL, READ: begin
          if (i_rd_req) begin
            re         = 1'b1;
            rd_valid_d = 1'b1;
            rd_ptr_d   = rd_ptr_q + NB_ADDR'(1);
            if (rd_ptr_q == LAST) begin
              state_d = IDLE;
              full_d  = 1'b0;
            end else begin
              state_d = READ;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  capture_ram #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_ram (
    .clock   (clock),
    .i_reset (i_reset),
    .i_we    (we),
    .i_waddr (wr_ptr_q),
    .i_wdata (i_data),
    .i_re    (re),
    .i_raddr (rd_ptr_q),
    .o_rdata (o_rd_data)
  );

  assign o_rd_valid = rd_valid_q;
  assign o_full     = full_q;
  assign o_state    = state_q;
  assign o_count    = count_q;

endmodule
